keypad_matrix_emu: RTL and testbench

KEYPAD_MATRIX_EMU -- requirements
Module: keypad_matrix_emu

---
 rtl/keypad_matrix_emu.sv | 113 +++++++++++
 tb/tb_keypad_matrix_emu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emu.sv
// Keypad matrix emulator: presses one encoded key on a 4x4 row/column matrix,
// with optional contact bounce at press and release and a forced open gap afterwards.
module keypad_matrix_emu #(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned GAP_CYCLES    = 500,
  parameter int unsigned BOUNCE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       abort,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, BOUNCE_ON, HOLD, BOUNCE_OFF, GAP} state_t;

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [31:0] BNC_LAST  = (BOUNCE_CYCLES == 0) ? 32'd0 : 32'(BOUNCE_CYCLES - 1);
  localparam logic        HAS_BNC   = (BOUNCE_CYCLES != 0);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  pat_q, pat_d;
  logic        err_q, err_d;
  logic        hs, dec_ok, contact, row_onehot;
  logic [7:0]  dec_pat;

  // Pattern is {col[3:0], row[3:0]}; operator codes already are patterns.
  always_comb begin
    dec_ok  = 1'b1;
    dec_pat = 8'h00;
    case (key_code)
      8'd0: dec_pat = 8'h81;
      8'd1: dec_pat = 8'h41;
      8'd2: dec_pat = 8'h42;
      8'd3: dec_pat = 8'h44;
      8'd4: dec_pat = 8'h21;
      8'd5: dec_pat = 8'h22;
      8'd6: dec_pat = 8'h24;
      8'd7: dec_pat = 8'h11;
      8'd8: dec_pat = 8'h12;
      8'd9: dec_pat = 8'h14;
      8'h82, 8'h84, 8'h88, 8'h18, 8'h48, 8'h28: dec_pat = key_code;
      default: dec_ok = 1'b0;
    endcase
  end

  assign hs = key_valid && key_ready;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        if (dec_ok) begin
          pat_d   = dec_pat;
          state_d = HAS_BNC ? BOUNCE_ON : HOLD;
        end else begin
          err_d = 1'b1;
        end
      end
      BOUNCE_ON:  if (abort) state_d = GAP;
                  else if (cnt_q == BNC_LAST) state_d = HOLD;
      HOLD:       if (abort) state_d = GAP;
                  else if (cnt_q == HOLD_LAST) state_d = HAS_BNC ? BOUNCE_OFF : GAP;
      BOUNCE_OFF: if (abort) state_d = GAP;
                  else if (cnt_q == BNC_LAST) state_d = GAP;
      GAP:        if (cnt_q == GAP_LAST) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    // Counter restarts on every state entry and saturates instead of wrapping.
    if (state_d != state_q || state_q == IDLE) cnt_d = 32'd0;
    else if (cnt_q == 32'hFFFF_FFFF)           cnt_d = cnt_q;
    else                                       cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      pat_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
    end
  end

  // Bounce bursts start closed: even counter values are contact, odd are open.
  always_comb begin
    case (state_q)
      HOLD:                  contact = 1'b1;
      BOUNCE_ON, BOUNCE_OFF: contact = ~cnt_q[0];
      default:               contact = 1'b0;
    endcase
  end

  assign row_onehot = (row_in != 4'd0) && ((row_in & (row_in - 4'd1)) == 4'd0);
  assign col_out    = (contact && row_onehot && row_in == pat_q[3:0]) ? pat_q[7:4] : 4'b0000;
  assign key_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Directed bench for keypad_matrix_emu: one instance without bounce, one with a
// three-cycle bounce burst, sharing code/row/abort/reset and with separate valids.
module tb_keypad_matrix_emu;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       kv0 = 1'b0, kv1 = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] row_in = 4'b0000;
  logic [3:0] col0, col1;
  logic       rdy0, rdy1, busy0, busy1, err0, err1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_matrix_emu #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(kv0), .key_ready(rdy0),
    .abort(abort), .row_in(row_in), .col_out(col0), .busy(busy0), .err(err0));

  keypad_matrix_emu #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(kv1), .key_ready(rdy1),
    .abort(abort), .row_in(row_in), .col_out(col1), .busy(busy1), .err(err1));

  typedef struct {
    logic [7:0] code;
    logic [3:0] row;
    logic [3:0] col;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] c);
    key_code = c; kv0 = 1'b1;
    step();
    kv0 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rdy0 && rdy1) && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, rdy0 && rdy1}, 32'd1);
  endtask

  initial begin
    logic [11:0] bexp;
    int          cyc;
    vt[0]  = '{8'd5,  4'b0010, 4'b0010};
    vt[1]  = '{8'd0,  4'b0001, 4'b1000};
    vt[2]  = '{8'd1,  4'b0001, 4'b0100};
    vt[3]  = '{8'd3,  4'b0100, 4'b0100};
    vt[4]  = '{8'd6,  4'b0100, 4'b0010};
    vt[5]  = '{8'd7,  4'b0001, 4'b0001};
    vt[6]  = '{8'd9,  4'b0100, 4'b0001};
    vt[7]  = '{8'h82, 4'b0010, 4'b1000};
    vt[8]  = '{8'h84, 4'b0100, 4'b1000};
    vt[9]  = '{8'h18, 4'b1000, 4'b0001};
    vt[10] = '{8'h48, 4'b1000, 4'b0100};
    vt[11] = '{8'h28, 4'b1000, 4'b0010};
    vt[12] = '{8'd5,  4'b0011, 4'b0000};
    vt[13] = '{8'd2,  4'b0001, 4'b0000};

    // Reset state, checked with no clock edge relevance
    #2;
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_busy",  {31'd0, busy0}, 32'd0);
    chk("rst_err",   {31'd0, err0}, 32'd0);
    row_in = 4'b0001;
    #1;
    chk("rst_col", {28'd0, col0}, 32'd0);
    step();
    #3 rst = 1'b1;
    step();

    // Decode table: check the sensed column in the first HOLD cycle
    for (int i = 0; i < 14; i++) begin
      row_in = vt[i].row;
      send0(vt[i].code);
      chk($sformatf("vec%0d_col", i), {28'd0, col0}, {28'd0, vt[i].col});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy0}, 32'd1);
      wait_idle();
    end

    // Basic press: code 5, row 0010 held
    row_in = 4'b0010;
    send0(8'd5);
    cyc = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_hold%0d", i), {28'd0, col0}, 32'b0010);
      step(); cyc++;
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("basic_gap%0d_col", i), {28'd0, col0}, 32'd0);
      chk($sformatf("basic_gap%0d_rdy", i), {31'd0, rdy0}, 32'd0);
      step(); cyc++;
    end
    chk("basic_ready", {31'd0, rdy0}, 32'd1);
    chk("basic_cycles", cyc, 32'd7);

    // Row sweep during HOLD of 0x88
    send0(8'h88);
    row_in = 4'b1000; #1 chk("sweep_1000", {28'd0, col0}, 32'b1000);
    row_in = 4'b0100; #1 chk("sweep_0100", {28'd0, col0}, 32'b0000);
    row_in = 4'b0010; #1 chk("sweep_0010", {28'd0, col0}, 32'b0000);
    row_in = 4'b0001; #1 chk("sweep_0001", {28'd0, col0}, 32'b0000);
    row_in = 4'b0000; #1 chk("sweep_none", {28'd0, col0}, 32'b0000);
    wait_idle();

    // Bounce: code 1 on the bouncing instance, row 0001
    row_in = 4'b0001;
    bexp = 12'b101_1111_101_00;
    key_code = 8'd1; kv1 = 1'b1;
    step();
    kv1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("bounce%0d", i), {28'd0, col1}, bexp[11-i] ? 32'b0100 : 32'd0);
      step();
    end
    chk("bounce_ready", {31'd0, rdy1}, 32'd1);

    // Invalid code
    chk("inv_err_before", {31'd0, err0}, 32'd0);
    send0(8'h0A);
    chk("inv_err",   {31'd0, err0}, 32'd1);
    chk("inv_busy",  {31'd0, busy0}, 32'd0);
    chk("inv_ready", {31'd0, rdy0}, 32'd1);
    chk("inv_col",   {28'd0, col0}, 32'd0);
    step();
    chk("inv_err_gone", {31'd0, err0}, 32'd0);

    // Abort in HOLD cycle 2, then an ignored abort pulse in GAP
    row_in = 4'b0010;
    send0(8'd8);
    chk("ab_hold1", {28'd0, col0}, 32'b0001);
    step();
    abort = 1'b1;
    chk("ab_hold2", {28'd0, col0}, 32'b0001);
    step();
    abort = 1'b0;
    chk("ab_col_off", {28'd0, col0}, 32'd0);
    chk("ab_gap0_busy", {31'd0, busy0}, 32'd1);
    step();
    abort = 1'b1;
    chk("ab_gap1_busy", {31'd0, busy0}, 32'd1);
    step();
    abort = 1'b0;
    chk("ab_idle", {31'd0, rdy0}, 32'd1);
    chk("ab_idle_col", {28'd0, col0}, 32'd0);

    // Abort together with handshake in IDLE: key wins
    abort = 1'b1;
    send0(8'd8);
    abort = 1'b0;
    chk("ab_hs_busy", {31'd0, busy0}, 32'd1);
    chk("ab_hs_col",  {28'd0, col0}, 32'b0001);
    wait_idle();

    // Asynchronous reset during HOLD, then immediate re-use
    row_in = 4'b0010;
    send0(8'd5);
    step();
    chk("rm_col_before", {28'd0, col0}, 32'b0010);
    #2 rst = 1'b0;
    #1;
    chk("rm_col",   {28'd0, col0}, 32'd0);
    chk("rm_busy",  {31'd0, busy0}, 32'd0);
    chk("rm_ready", {31'd0, rdy0}, 32'd1);
    #2 rst = 1'b1;
    row_in = 4'b0001;
    send0(8'd4);
    chk("rm_new_busy", {31'd0, busy0}, 32'd1);
    chk("rm_new_col",  {28'd0, col0}, 32'b0010);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
